// File: rtl/microwave_controller_if.sv
// Front-panel, timer-datapath and status signals of the microwave controller.
// The controller is the slave; the panel/timer environment is the master.
interface microwave_controller_if;
   logic        keypad_valid;
   logic [3:0]  keypad_digit;
   logic        startn;
   logic        stopn;
   logic        door_closed;
   logic        timer_zero;
   logic        timer_loadn;
   logic        timer_en;
   logic [11:0] timer_preset;
   logic        mag_on;
   logic        done_beep;
   logic [2:0]  state;

   modport master (
      output keypad_valid, keypad_digit, startn, stopn, door_closed, timer_zero,
      input  timer_loadn, timer_en, timer_preset, mag_on, done_beep, state
   );

   modport slave (
      input  keypad_valid, keypad_digit, startn, stopn, door_closed, timer_zero,
      output timer_loadn, timer_en, timer_preset, mag_on, done_beep, state
   );
endinterface

// File: rtl/microwave_controller.sv
// Microwave cook controller: keypad preset entry, timer load, 1 s tick gating,
// door interlock, pause/resume, stop/clear and end-of-cook beep.
module microwave_controller #(
   parameter int TICK_DIV    = 100,
   parameter int BEEP_CYCLES = 50
) (
   input  logic                  clock,
   input  logic                  clrn,
   microwave_controller_if.slave bus
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BW = $clog2(BEEP_CYCLES + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_COOK  = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        r_state, w_next;
   logic          r_startn_q, r_stopn_q;
   logic [11:0]   r_preset, w_preset_nxt;
   logic [PW-1:0] r_presc, w_presc_nxt;
   logic [BW-1:0] r_beep, w_beep_nxt;
   logic          w_start_evt, w_stop_evt, w_tick, w_start_ok;

   // Stop dominates a simultaneous start press.
   assign w_stop_evt  = r_stopn_q & ~bus.stopn;
   assign w_start_evt = r_startn_q & ~bus.startn & ~w_stop_evt;
   assign w_tick      = (r_presc == PRESC_LAST);
   assign w_start_ok  = bus.door_closed && (r_preset != 12'h000) && (r_preset[7:4] <= 4'd5);

   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         r_state    <= S_IDLE;
         r_startn_q <= 1'b1;
         r_stopn_q  <= 1'b1;
         r_preset   <= '0;
         r_presc    <= '0;
         r_beep     <= '0;
      end else begin
         r_state    <= w_next;
         r_startn_q <= bus.startn;
         r_stopn_q  <= bus.stopn;
         r_preset   <= w_preset_nxt;
         r_presc    <= w_presc_nxt;
         r_beep     <= w_beep_nxt;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_preset_nxt = r_preset;
      w_presc_nxt  = r_presc;
      w_beep_nxt   = r_beep;
      case (r_state)
         S_IDLE: begin
            if (w_stop_evt) begin
               w_preset_nxt = '0;
            end else begin
               if (bus.keypad_valid && (bus.keypad_digit <= 4'd9))
                  w_preset_nxt = {r_preset[7:0], bus.keypad_digit};
               if (w_start_evt && w_start_ok)
                  w_next = S_LOAD;
            end
         end
         S_LOAD: begin
            w_presc_nxt = '0;
            w_next      = S_COOK;
         end
         S_COOK: begin
            // Timer reaching zero outranks the interlock; the prescaler freezes on pause.
            if (bus.timer_zero)
               w_next = S_DONE;
            else if (!bus.door_closed || w_stop_evt)
               w_next = S_PAUSE;
            else
               w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
         end
         S_PAUSE: begin
            if (w_stop_evt) begin
               w_next       = S_IDLE;
               w_preset_nxt = '0;
            end else if (w_start_evt && bus.door_closed) begin
               w_next = S_COOK;
            end
         end
         S_DONE: begin
            if (w_stop_evt || (r_beep == BEEP_LAST)) begin
               w_next       = S_IDLE;
               w_preset_nxt = '0;
               w_beep_nxt   = '0;
            end else begin
               w_beep_nxt = r_beep + 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // A tick is dropped if the door opens, stop is pressed or the timer hits zero.
   assign bus.timer_en     = (r_state == S_COOK) && w_tick && !bus.timer_zero &&
                             bus.door_closed && !w_stop_evt;
   assign bus.timer_loadn  = (r_state != S_LOAD);
   assign bus.timer_preset = r_preset;
   assign bus.mag_on       = (r_state == S_COOK);
   assign bus.done_beep    = (r_state == S_DONE);
   assign bus.state        = r_state;
endmodule
